arith_rem_share: RTL and testbench
==================================

# arith_rem_share

Shared, multi-cycle signed-remainder engine that time-multiplexes one iterative remainder datapath among `NUM_REQ` requesters. Each requester has its own operand and result handshake channels. A round-robin arbiter grants one request at a time. A radix-2 restoring sequencer computes `signed(a) % signed(b)` (C semantics, truncating) over `WIDTH` cycles. The block replaces per-lane combinational remainder units wherever remainder throughput is low and area matters.

## Interface
- `WIDTH`, default 32: operand/result width in bits (≥2).
- `NUM_REQ`, default 4: number of requesters (≥1).

Ports:
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `req_valid`  in  NUM_REQ  per-requester operand valid.
- `req_ready`  out  NUM_REQ  per-requester operand accept.
- `req_a`  in  NUM_REQ*WIDTH  dividends; lane i at bits [i*WIDTH +: WIDTH].
- `req_b`  in  NUM_REQ*WIDTH  divisors, same packing.
- `resp_valid`  out  NUM_REQ  per-requester result valid.
- `resp_ready`  in  NUM_REQ  per-requester result accept.
- `resp_data`  out  NUM_REQ*WIDTH  results, same packing.
- `busy`  out  1  high whenever state ≠ IDLE.

## Operation
- States: IDLE, CALC, DONE.
- **IDLE:**
  - Arbiter picks the first asserted `req_valid[i]`, scanning from `(last+1) mod NUM_REQ` upward with wrap.
  - Only the picked lane gets `req_ready[i]`=1. `req_ready` is combinational from `req_valid` in IDLE and 0 in all other states.
  - On handshake:
    - Latch grant index `g` and set `last`←g.
    - Latch `|a|` and `|b|` as WIDTH-bit unsigned magnitudes, so |INT_MIN| = 2^(WIDTH-1).
    - Latch sign of a.
  - Next state:
    - If b==0, go to DONE with result = a unchanged.
    - Otherwise, go to CALC with partial remainder 0, shift register `|a|`, and bit counter = WIDTH-1.
- **CALC:**
  - Each cycle, shift the next dividend MSB into the partial remainder. If partial ≥ `|b|`, subtract `|b|`.
  - The partial remainder register is WIDTH+1 bits to avoid overflow.
  - Counter decrements each cycle. After the step with counter==0, go to DONE.
- **DONE:**
  - `resp_valid[g]`=1.
  - `resp_data[g]` = partial remainder if a ≥ 0, else its two's-complement negation (remainder sign follows the dividend).
  - On `resp_ready[g]`=1, return to IDLE. No new request is accepted in the same cycle.
- Non-granted lanes: `resp_valid`=0 and `resp_data`=0. The granted lane's `resp_data` is 0 outside DONE.
- Special values fall out of the algorithm; no extra logic:
  - INT_MIN % -1 = 0.
  - INT_MIN % 1 = 0.
  - a % INT_MIN = a for a ≠ INT_MIN.
- **Reset:**
  - State←IDLE, `last`←NUM_REQ-1 (so lane 0 wins first), counters and data registers 0.
  - All outputs 0 (`req_ready` then follows IDLE arbitration as soon as reset releases).
  - An in-flight operation is discarded with no response.

## Timing
- Accept in cycle T (valid & ready at the edge ending T):
  - b≠0: CALC occupies T+1 .. T+WIDTH, and `resp_valid` rises at T+WIDTH+1.
  - b==0: `resp_valid` rises at T+1.
- `resp_valid` and `resp_data` are registered or decoded from registers only, and stay stable until `resp_ready`.
- Result consumed at cycle R means the earliest next accept is R+1, giving a throughput of one op per WIDTH+2 cycles, or 2 for b==0.
- Requesters may drop `req_valid` before acceptance; the arbiter re-evaluates every IDLE cycle.
- Operands are sampled only at the handshake edge. Later changes on `req_a`/`req_b` have no effect.
- Fairness: with all lanes continuously valid, grants rotate 0,1,…,NUM_REQ-1,0. No lane waits more than NUM_REQ-1 other operations.
- Simultaneous `rst` and handshake: reset wins and nothing is latched.

## Test plan
All scenarios use WIDTH=8, NUM_REQ=4.
- **Signs:** lane0 a=-7, b=2 → `resp_data`[0]=0xFF (-1) at T+9. Then a=7, b=-2 → 0x01. Then a=-7, b=-2 → 0xFF. Then a=7, b=2 → 0x01.
- **Edges:** a=-128, b=-1 → 0x00. a=-128, b=3 → 0xFE (-2). a=5, b=-128 → 0x05. a=-128, b=-128 → 0x00. a=0, b=7 → 0x00.
- **Divide by zero:** lane2 a=-5, b=0 → `resp_valid`[2] at T+1 with data 0xFB. `busy` is high exactly 1 cycle.
- **Round-robin:** all four lanes hold valid with distinct operands → grant order 0,1,2,3,0. Each response lands on its own lane with the correct value, and other lanes' `resp_valid` stay 0.
- **Backpressure:** `resp_ready`[1]=0 for 5 cycles in DONE → data held constant, `req_ready` all 0, `busy`=1. When `resp_ready` rises, next accept occurs the following cycle.
- **Reset mid-op:** assert `rst` at CALC step 3 → all outputs 0 immediately, no stale response after release. The first post-reset request on lane 3 with lanes 0 and 3 both valid grants lane 0.

Source files
------------

// File: rtl/arith_rem_share.sv
// Shared multi-cycle signed remainder engine: a round-robin arbiter feeds one
// radix-2 restoring datapath that computes signed(a) % signed(b) with C truncation.
module arith_rem_share #(
  parameter int WIDTH   = 32,
  parameter int NUM_REQ = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  output logic [NUM_REQ-1:0]       resp_valid,
  input  logic [NUM_REQ-1:0]       resp_ready,
  output logic [NUM_REQ*WIDTH-1:0] resp_data,
  output logic                     busy
);

  localparam int IDXW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNTW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state, state_nxt;
  logic [IDXW-1:0]  last, grant, pick;
  logic             found;
  logic             accept, consume;
  logic [WIDTH-1:0] a_sel, b_sel, a_mag, b_mag_sel;
  logic [WIDTH-1:0] b_mag, a_sh, result;
  logic [WIDTH:0]   rem;
  logic [WIDTH+1:0] shifted, diff;
  logic [CNTW-1:0]  cnt;
  logic             a_neg;

  // Round-robin pick: scan from last+1 upward with wrap; the lowest offset wins.
  // NOTE: every signal driven in always_comb gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      if (req_valid[(int'(last) + k) % NUM_REQ]) begin
        pick  = IDXW'((int'(last) + k) % NUM_REQ);
        found = 1'b1;
      end
    end
  end

  // Reset gates acceptance so a handshake coincident with rst latches nothing.
  assign accept  = (state == IDLE) && found && !rst;
  assign consume = (state == DONE) && resp_ready[grant];

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[pick] = 1'b1;
  end

  assign a_sel     = req_a[int'(pick)*WIDTH +: WIDTH];
  assign b_sel     = req_b[int'(pick)*WIDTH +: WIDTH];
  // Unsigned magnitudes: INT_MIN maps onto 2^(WIDTH-1) without overflow.
  assign a_mag     = a_sel[WIDTH-1] ? -a_sel : a_sel;
  assign b_mag_sel = b_sel[WIDTH-1] ? -b_sel : b_sel;

  // One restoring step: shift in the next dividend bit, subtract if no borrow.
  assign shifted = {rem, a_sh[WIDTH-1]};
  assign diff    = shifted - {2'b00, b_mag};

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept) state_nxt = (b_sel == '0) ? DONE : CALC;
      CALC:    if (cnt == '0) state_nxt = DONE;
      DONE:    if (consume) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: datapath registers are reset as well, so no stale operand or result
  // survives a reset that lands mid-operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last  <= IDXW'(NUM_REQ - 1);
      grant <= '0;
      a_neg <= 1'b0;
      b_mag <= '0;
      a_sh  <= '0;
      rem   <= '0;
      cnt   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            grant <= pick;
            last  <= pick;
            a_neg <= a_sel[WIDTH-1];
            b_mag <= b_mag_sel;
            a_sh  <= a_mag;
            cnt   <= CNTW'(WIDTH - 1);
            // Divide by zero returns a: the sign fix-up in DONE restores it.
            rem   <= (b_sel == '0) ? {1'b0, a_mag} : '0;
          end
        end
        CALC: begin
          rem  <= diff[WIDTH+1] ? shifted[WIDTH:0] : diff[WIDTH:0];
          a_sh <= a_sh << 1;
          cnt  <= cnt - CNTW'(1);
        end
        default: ;
      endcase
    end
  end

  assign result = a_neg ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];

  always_comb begin
    resp_valid = '0;
    resp_data  = '0;
    if (state == DONE) begin
      resp_valid[grant]                    = 1'b1;
      resp_data[int'(grant)*WIDTH +: WIDTH] = result;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_arith_rem_share.sv
// Directed bench for arith_rem_share (WIDTH=8, NUM_REQ=4): vector table plus
// hand-written round-robin, backpressure and mid-operation reset sequences.
module tb_arith_rem_share;
  localparam int W = 8;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid, req_ready, resp_valid, resp_ready;
  logic [N*W-1:0] req_a, req_b, resp_data;
  logic           busy;

  int checks = 0;
  int errors = 0;

  arith_rem_share #(.WIDTH(W), .NUM_REQ(N)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         lane;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] r;
    int         lat;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_lane(input int lane, input logic [7:0] a, input logic [7:0] b);
    req_a[lane*W +: W] = a;
    req_b[lane*W +: W] = b;
  endtask

  function automatic logic [7:0] lane_data(input int lane);
    return resp_data[lane*W +: W];
  endfunction

  function automatic int onehot_idx(input logic [N-1:0] v);
    int idx = -1;
    for (int i = 0; i < N; i++) if (v[i]) idx = i;
    return idx;
  endfunction

  // Wait (bounded) for any resp_valid, sampling 1 time unit after each edge.
  task automatic wait_resp(input string name);
    int n = 0;
    while (resp_valid == '0 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (resp_valid == '0) check({name, " resp timeout"}, 0, 1);
  endtask

  task automatic run_op(input vec_t v, input int id);
    int n;
    string nm;
    nm = $sformatf("vec%0d", id);
    @(negedge clk);
    set_lane(v.lane, v.a, v.b);
    req_valid[v.lane] = 1'b1;
    n = 0;
    while (!req_ready[v.lane] && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({nm, " req_ready"}, 32'(req_ready), 32'(1 << v.lane));
    @(posedge clk); #1;
    req_valid[v.lane] = 1'b0;
    // Scramble operands after the handshake: they must not matter any more.
    set_lane(v.lane, ~v.a, ~v.b);
    check({nm, " busy after accept"}, 32'(busy), 1);
    n = 0;
    while (!resp_valid[v.lane] && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check({nm, " latency"}, n + 1, v.lat);
    check({nm, " data"}, 32'(lane_data(v.lane)), 32'(v.r));
    check({nm, " resp_valid onehot"}, 32'(resp_valid), 32'(1 << v.lane));
    @(posedge clk); #1;
    check({nm, " busy after consume"}, 32'(busy), 0);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [7:0] rr_exp[4];
    int         rr_order[5];
    int         lane;

    vecs[0]  = '{0, 8'hF9, 8'h02, 8'hFF, 9};  // -7 % 2
    vecs[1]  = '{0, 8'h07, 8'hFE, 8'h01, 9};  // 7 % -2
    vecs[2]  = '{0, 8'hF9, 8'hFE, 8'hFF, 9};  // -7 % -2
    vecs[3]  = '{0, 8'h07, 8'h02, 8'h01, 9};  // 7 % 2
    vecs[4]  = '{0, 8'h80, 8'hFF, 8'h00, 9};  // -128 % -1
    vecs[5]  = '{0, 8'h80, 8'h03, 8'hFE, 9};  // -128 % 3
    vecs[6]  = '{0, 8'h05, 8'h80, 8'h05, 9};  // 5 % -128
    vecs[7]  = '{0, 8'h80, 8'h80, 8'h00, 9};  // -128 % -128
    vecs[8]  = '{0, 8'h00, 8'h07, 8'h00, 9};  // 0 % 7
    vecs[9]  = '{2, 8'hFB, 8'h00, 8'hFB, 1};  // -5 % 0
    vecs[10] = '{1, 8'h64, 8'h07, 8'h02, 9};  // 100 % 7
    vecs[11] = '{3, 8'h9C, 8'h07, 8'hFE, 9};  // -100 % 7
    vecs[12] = '{0, 8'h7F, 8'h80, 8'h7F, 9};  // 127 % -128
    vecs[13] = '{1, 8'h80, 8'h01, 8'h00, 9};  // -128 % 1

    rst = 1'b1;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    resp_ready = '1;

    // Reset state.
    #1;
    check("reset busy", 32'(busy), 0);
    check("reset resp_valid", 32'(resp_valid), 0);
    check("reset resp_data", resp_data, 0);
    check("reset req_ready", 32'(req_ready), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("idle req_ready", 32'(req_ready), 0);
    check("idle busy", 32'(busy), 0);

    for (int i = 0; i < 14; i++) run_op(vecs[i], i);

    // Round-robin with all lanes continuously valid.
    pulse_reset();
    set_lane(0, 8'd20, 8'd6);   rr_exp[0] = 8'h02;
    set_lane(1, 8'hEC, 8'd6);   rr_exp[1] = 8'hFE;  // -20 % 6
    set_lane(2, 8'd33, 8'hFB);  rr_exp[2] = 8'h03;  // 33 % -5
    set_lane(3, 8'hDF, 8'hFB);  rr_exp[3] = 8'hFD;  // -33 % -5
    rr_order = '{0, 1, 2, 3, 0};
    req_valid = '1;
    for (int i = 0; i < 5; i++) begin
      wait_resp($sformatf("rr%0d", i));
      check($sformatf("rr%0d single valid", i), $countones(resp_valid), 1);
      lane = onehot_idx(resp_valid);
      check($sformatf("rr%0d grant", i), lane, rr_order[i]);
      check($sformatf("rr%0d data", i), 32'(lane_data(rr_order[i])), 32'(rr_exp[rr_order[i]]));
      if (i == 4) req_valid = '0;
      @(posedge clk); #1;
    end
    check("rr idle", 32'(busy), 0);

    // Backpressure on lane 1 while lane 0 waits.
    @(negedge clk);
    set_lane(1, 8'd23, 8'd5);
    resp_ready[1] = 1'b0;
    req_valid[1] = 1'b1;
    #1;
    check("bp accept lane1", 32'(req_ready), 32'b0010);
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    set_lane(0, 8'd9, 8'd4);
    req_valid[0] = 1'b1;
    wait_resp("bp");
    for (int k = 0; k < 5; k++) begin
      check($sformatf("bp hold data %0d", k), 32'(lane_data(1)), 32'h03);
      check($sformatf("bp hold valid %0d", k), 32'(resp_valid), 32'b0010);
      check($sformatf("bp req_ready %0d", k), 32'(req_ready), 0);
      check($sformatf("bp busy %0d", k), 32'(busy), 1);
      @(posedge clk); #1;
    end
    resp_ready[1] = 1'b1;
    @(posedge clk); #1;
    check("bp consumed busy", 32'(busy), 0);
    check("bp next ready", 32'(req_ready), 32'b0001);
    @(posedge clk); #1;
    check("bp next accept", 32'(busy), 1);
    req_valid[0] = 1'b0;
    wait_resp("bp lane0");
    check("bp lane0 valid", 32'(resp_valid), 32'b0001);
    check("bp lane0 data", 32'(lane_data(0)), 32'h01);
    @(posedge clk); #1;

    // Reset in the middle of CALC.
    @(negedge clk);
    set_lane(0, 8'd50, 8'd7);
    req_valid[0] = 1'b1;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    check("mid busy before rst", 32'(busy), 1);
    set_lane(3, 8'hF7, 8'd4);   // -9 % 4
    req_valid = 4'b1001;
    rst = 1'b1;
    #1;
    check("rst busy", 32'(busy), 0);
    check("rst resp_valid", 32'(resp_valid), 0);
    check("rst resp_data", resp_data, 0);
    check("rst req_ready", 32'(req_ready), 0);
    @(posedge clk); #1;
    check("rst held req_ready", 32'(req_ready), 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post rst grant lane0", 32'(req_ready), 32'b0001);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    check("post rst accept", 32'(busy), 1);
    wait_resp("post rst lane0");
    check("post rst lane0 valid", 32'(resp_valid), 32'b0001);
    check("post rst lane0 data", 32'(lane_data(0)), 32'h01);
    @(posedge clk); #1;
    wait_resp("post rst lane3");
    req_valid[3] = 1'b0;
    check("post rst lane3 valid", 32'(resp_valid), 32'b1000);
    check("post rst lane3 data", 32'(lane_data(3)), 32'hFF);
    @(posedge clk); #1;
    check("final idle", 32'(busy), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
